// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: FSM encoding, default width,
// and the saturating increment used by the job statistics counters.
package gcd_pkg;

    localparam int GCD_WIDTH_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Increment v, but stop at the all-ones value of a w-bit counter
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/gcd_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at its maximum,
// cleared only by reset.
module gcd_sat_counter
    import gcd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    // Count up on inc, holding at the top value instead of wrapping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc) begin
            value <= CNT_W'(sat_inc(64'(value), CNT_W));
        end
    end

endmodule

// File: rtl/gcd_requester.sv
// Initiator for a GCD core start/done handshake: takes operand pairs from a
// valid/ready stream, pulses start, waits (with timeout) for done, and offers
// the captured result on a downstream valid/ready stream.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH_DEF,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             spurious,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_tmo
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             job_ok;
    logic             job_tmo;

    // in_ready is forced low while reset is held, even though state is IDLE
    assign in_ready  = reset_n && (state == ST_IDLE);
    assign gcd_start = (state == ST_ISSUE);
    assign out_valid = (state == ST_HOLD);
    assign gcd_a     = a_q;
    assign gcd_b     = b_q;

    assign accept  = in_valid && in_ready;
    // done has priority over a timeout landing in the same cycle
    assign job_ok  = (state == ST_WAIT) && gcd_done;
    assign job_tmo = (state == ST_WAIT) && !gcd_done && (timer == TMR_LAST);

    // Next-state decode for the request/wait/hold sequence
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (job_ok || job_tmo) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any job in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Operand capture; held unchanged from ISSUE through HOLD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // WAIT-cycle timer, restarted in ISSUE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                timer <= '0;
        else if (state == ST_ISSUE)  timer <= '0;
        else if (state == ST_WAIT)   timer <= timer + 1'b1;
    end

    // Result capture: core result on done, zero plus error flag on timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (job_ok) begin
            out_data <= gcd_outp;
            out_err  <= 1'b0;
        end else if (job_tmo) begin
            out_data <= '0;
            out_err  <= 1'b1;
        end
    end

    // Sticky flag for done pulses arriving when no job is waiting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          spurious <= 1'b0;
        else if (gcd_done && state != ST_WAIT) spurious <= 1'b1;
    end

    gcd_sat_counter #(.CNT_W(CNT_W)) u_cnt_ok (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (job_ok),
        .value   (cnt_ok)
    );

    gcd_sat_counter #(.CNT_W(CNT_W)) u_cnt_tmo (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (job_tmo),
        .value   (cnt_tmo)
    );

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural GCD core model and a
// result scoreboard.
module tb_gcd_requester;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          gcd_start;
    logic [W-1:0]  gcd_a;
    logic [W-1:0]  gcd_b;
    logic          gcd_done;
    logic [W-1:0]  gcd_outp;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic          spurious;
    logic [CW-1:0] cnt_ok;
    logic [CW-1:0] cnt_tmo;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .gcd_start (gcd_start),
        .gcd_a     (gcd_a),
        .gcd_b     (gcd_b),
        .gcd_done  (gcd_done),
        .gcd_outp  (gcd_outp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .spurious  (spurious),
        .cnt_ok    (cnt_ok),
        .cnt_tmo   (cnt_tmo)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        if (a == 0 || b == 0) return '0;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: done fires done_delay cycles after the start cycle (0 = never)
    int unsigned  cyc = 0;
    int unsigned  start_cyc = 0;
    int           done_delay = 10;
    logic         armed = 1'b0;
    logic         manual_done = 1'b0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    logic         model_done;

    assign model_done = armed && (done_delay != 0) && (cyc == start_cyc + done_delay);
    assign gcd_done   = model_done | manual_done;
    assign gcd_outp   = ref_gcd(ma, mb);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (gcd_start) begin
            armed     <= 1'b1;
            start_cyc <= cyc;
            ma        <= gcd_a;
            mb        <= gcd_b;
        end else if (model_done) begin
            armed <= 1'b0;
        end
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ok = 0;
    int   exp_tmo = 0;
    int   max_cnt = (1 << CW) - 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // One complete job: issue, latency measurement, optional back-pressure, drain
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int delay, input int exp_lat, input int bp);
        int   lat;
        exp_t e;
        done_delay = delay;
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        if (delay == 0) sb.push_back('{data: '0, err: 1'b1});
        else            sb.push_back('{data: ref_gcd(a, b), err: 1'b0});
        tick();
        in_valid = 1'b0;
        check("start_high", gcd_start, 1);
        check("issue_a", gcd_a, a);
        check("issue_b", gcd_b, b);
        tick();
        check("start_one_cycle", gcd_start, 0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        check("sb_pending", sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '{data: 'x, err: 1'bx};
        if (e.err) exp_tmo = (exp_tmo == max_cnt) ? exp_tmo : exp_tmo + 1;
        else       exp_ok  = (exp_ok  == max_cnt) ? exp_ok  : exp_ok  + 1;
        check("out_data", out_data, e.data);
        check("out_err", out_err, e.err);
        check("hold_a", gcd_a, a);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, e.data);
            check("bp_err", out_err, e.err);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_idle", in_ready, 1);
        check("cnt_ok", cnt_ok, exp_ok);
        check("cnt_tmo", cnt_tmo, exp_tmo);
    endtask

    initial begin
        int saw;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_start", gcd_start, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_spurious", spurious, 0);
        check("rst_cnt_ok", cnt_ok, 0);
        check("rst_cnt_tmo", cnt_tmo, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);

        run_job(8'd12, 8'd18, 10, 10, 0);
        run_job(8'd0,  8'd5,  10, 10, 0);
        run_job(8'd77, 8'd11, 0,  TO, 0);
        run_job(8'd63, 8'd42, 10, 10, 5);
        run_job(8'd8,  8'd12, 10, 10, 0);
        check("no_spurious_yet", spurious, 0);

        // Reset in the middle of WAIT drops the job
        done_delay = 10;
        wait_ready();
        in_valid = 1'b1;
        in_a     = 8'd35;
        in_b     = 8'd14;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        sb.delete();
        exp_ok  = 0;
        exp_tmo = 0;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_start", gcd_start, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_err", out_err, 0);
        check("mid_rst_cnt_ok", cnt_ok, 0);
        check("mid_rst_cnt_tmo", cnt_tmo, 0);
        check("mid_rst_a", gcd_a, 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        saw = 0;
        repeat (20) begin
            tick();
            if (out_valid) saw = 1;
        end
        check("dropped_no_valid", saw, 0);
        check("dropped_no_spurious", spurious, 0);

        // Done pulse while idle
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        check("spurious_set", spurious, 1);
        check("spurious_no_valid", out_valid, 0);
        check("spurious_cnt_ok", cnt_ok, exp_ok);
        check("spurious_cnt_tmo", cnt_tmo, exp_tmo);
        repeat (3) tick();
        check("spurious_sticky", spurious, 1);

        // Done coincident with the last timeout cycle counts as success
        run_job(8'd9, 8'd6, TO, TO, 0);
        check("spurious_still", spurious, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
Initiator side of the GCD core start/done handshake. It accepts operand pairs from an upstream valid/ready channel and issues each pair to the GCD core with a one-cycle start pulse. It then waits for the core's done pulse and captures the result, and presents it on a downstream valid/ready channel. It also provides a timeout guard and saturating job statistics, so GCD cores can sit behind standard streaming interfaces.

Parameters:
WIDTH, 8, operand/result width; must match the attached GCD core.
TIMEOUT, 1024, max cycles spent in WAIT before declaring a timeout; must be >= 2.
CNT_W, 16, width of each statistics counter.

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream operand pair valid
in_ready  out  1  block can accept a pair
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
gcd_start  out  1  start pulse to the core
gcd_a  out  WIDTH  operand a to the core
gcd_b  out  WIDTH  operand b to the core
gcd_done  in  1  one-cycle done pulse from the core
gcd_outp  in  WIDTH  core result, valid when gcd_done=1
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  GCD result
out_err  out  1  1 = timeout; out_data is 0
spurious  out  1  sticky flag: gcd_done was seen outside WAIT
cnt_ok  out  CNT_W  completed jobs, saturating
cnt_tmo  out  CNT_W  timed-out jobs, saturating

Behaviour:
- Reset (reset_n=0, any state, asynchronous):
  - state=IDLE.
  - Operand registers, timer, out_data, out_err, spurious, cnt_ok and cnt_tmo all cleared to 0.
  - gcd_start=0, out_valid=0, in_ready=0 while reset is asserted.
  - A job in flight when reset asserts is dropped, with no output.
- States: IDLE, ISSUE, WAIT, HOLD (2-bit encoding).
- IDLE:
  - in_ready=1 in IDLE only.
  - On in_valid&&in_ready: latch in_a/in_b, go to ISSUE.
- ISSUE:
  - gcd_start=1 for exactly this one cycle.
  - gcd_a/gcd_b come from the latched registers and stay stable from ISSUE through HOLD.
  - Timer cleared; next state WAIT.
- WAIT:
  - Timer increments by 1 each cycle.
  - If gcd_done=1: out_data<=gcd_outp, out_err<=0, cnt_ok++ (saturating), go to HOLD.
  - Else if timer==TIMEOUT-1: out_data<=0, out_err<=1, cnt_tmo++ (saturating), go to HOLD.
  - If gcd_done and the timeout coincide in the same cycle, done wins: the job counts as success.
- HOLD:
  - out_valid=1; out_data and out_err held stable.
  - On out_ready=1: go to IDLE. No bypass: a new pair is accepted at the earliest one cycle after the handshake.
- gcd_done=1 in IDLE, ISSUE or HOLD: the pulse is ignored for data and sets spurious=1. spurious clears only on reset.
- Latency: pair accepted at edge N; gcd_start high in cycle N+1; WAIT begins N+2.
  - If done arrives at cycle D, out_valid rises the cycle after D.
  - Worst-case timeout: out_valid rises TIMEOUT cycles after WAIT entry.
- Outputs are registered, except:
  - in_ready and gcd_start are decoded from state;
  - out_valid is decoded from state (==HOLD).
- Counters stop at 2^CNT_W-1 and do not wrap.
- Operands of 0 are passed through unchanged; the core defines the result (0). No special-casing here.

Decomposition:
- Shared package gcd_pkg holds:
  - state typedef and encodings (IDLE=0, ISSUE=1, WAIT=2, HOLD=3);
  - default WIDTH;
  - a saturating-increment function, reused for both counters.
- One natural sub-module: gcd_sat_counter (parameter CNT_W; ports inc, clear-on-reset, value), instantiated twice.
- The timer stays inline, sized $clog2(TIMEOUT+1).

Test Plan:
- Bench uses a GCD core model that raises done 10 cycles after start. Send in_a=12, in_b=18 -> gcd_start pulses exactly one cycle with gcd_a=12, gcd_b=18; out_valid with out_data=6, out_err=0; cnt_ok=1.
- in_a=0, in_b=5; model returns 0 -> out_data=0, out_err=0, cnt_ok increments; no special handling.
- TIMEOUT=16; model never raises done -> out_valid exactly 16 cycles after WAIT entry; out_data=0, out_err=1, cnt_tmo=1.
- Back-pressure: hold out_ready=0 for 5 cycles with result 21 (inputs 63,42) -> out_data and out_err stable throughout, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Assert reset_n=0 mid-WAIT for pair 35,14 -> all outputs return to their reset values immediately. After release: in_ready=1 and no out_valid for the dropped job.
- Pulse gcd_done while in IDLE -> spurious=1 and sticky, no out_valid, counters unchanged. Then drive gcd_done coincident with the timeout cycle (TIMEOUT=16) -> out_err=0 and cnt_ok increments.
